// File: rtl/mul8u_seq_pkg.sv
// rtl/mul8u_seq_pkg.sv - shared types, step tables and step-selection helpers for mul8u_seq_ctrl
package mul8u_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic [1:0] step_t;

    // Bit k set: step k takes the high nibble of that operand.
    localparam logic [3:0] STEP_A_HI = 4'b1010;
    localparam logic [3:0] STEP_B_HI = 4'b1100;

    localparam logic [3:0] SHIFT_LO  = 4'd0;
    localparam logic [3:0] SHIFT_MID = 4'd4;
    localparam logic [3:0] SHIFT_HI  = 4'd8;

    function automatic logic [3:0] step_shift(input step_t k);
        logic [3:0] s;
        case (k)
            2'd0:    s = SHIFT_LO;
            2'd3:    s = SHIFT_HI;
            default: s = SHIFT_MID;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nib(input logic [7:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

    // Steps that must run for this operand pair; all four when zero-skip is off.
    function automatic logic [3:0] req_mask(input logic [7:0] a, input logic [7:0] b,
                                            input logic skip);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k] = !skip || ((nib(a, STEP_A_HI[k]) != 4'd0) && (nib(b, STEP_B_HI[k]) != 4'd0));
        end
        return m;
    endfunction

    // Lowest required step index >= start; bit 2 set means none remain.
    function automatic logic [2:0] first_req(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] r;
        r = 3'd4;
        for (int j = 3; j >= 0; j--) begin
            if (mask[j] && (3'(j) >= start)) begin
                r = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul8u_seq_if.sv
// rtl/mul8u_seq_if.sv - operand/product handshake and shared-core bus for mul8u_seq_ctrl
interface mul8u_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        mul_en;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_p,
        output in_ready, out_valid, out_p, mul_en, mul_a, mul_b, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_p,
        input  in_ready, out_valid, out_p, mul_en, mul_a, mul_b, busy
    );

endinterface

// File: rtl/mul8u_step_acc.sv
// rtl/mul8u_step_acc.sv - nibble selection and shifted accumulate for one multiply step
module mul8u_step_acc
    import mul8u_seq_pkg::*;
(
    input  step_t       step,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic [7:0]  mul_p,
    input  logic        acc_en,
    input  logic [15:0] acc_q,
    output logic [3:0]  nib_a,
    output logic [3:0]  nib_b,
    output logic [15:0] acc_upd
);

    always_comb begin
        nib_a   = nib(op_a, STEP_A_HI[step]);
        nib_b   = nib(op_b, STEP_B_HI[step]);
        acc_upd = acc_q;
        if (acc_en) begin
            // Wraps modulo 2^16 on purpose: an inexact core may overshoot.
            acc_upd = acc_q + ({8'd0, mul_p} << step_shift(step));
        end
    end

endmodule

// File: rtl/mul8u_seq_ctrl.sv
// rtl/mul8u_seq_ctrl.sv - sequential 8x8 unsigned multiplier time-sharing one external 4x4 core
module mul8u_seq_ctrl
    import mul8u_seq_pkg::*;
#(
    parameter int SKIP_ZERO = 0,
    parameter int MUL_LAT   = 0
)(
    input  logic      clk,
    input  logic      rst,
    mul8u_seq_if.slave bus
);

    state_t      state_q, state_d;
    step_t       step_q, step_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] out_p_q, out_p_d;

    logic        acc_en;
    logic        live;
    logic [3:0]  nib_a, nib_b;
    logic [15:0] acc_upd;
    logic [2:0]  first_nxt;
    logic [2:0]  adv_nxt;

    assign live   = (state_q == ST_STEP) || (state_q == ST_WAIT);
    // A registered core delivers its product one cycle later, in WAIT.
    assign acc_en = (state_q == ST_WAIT) || ((state_q == ST_STEP) && (MUL_LAT == 0));

    mul8u_step_acc u_step_acc (
        .step    (step_q),
        .op_a    (a_q),
        .op_b    (b_q),
        .mul_p   (bus.mul_p),
        .acc_en  (acc_en),
        .acc_q   (acc_q),
        .nib_a   (nib_a),
        .nib_b   (nib_b),
        .acc_upd (acc_upd)
    );

    always_comb begin
        first_nxt = first_req(req_mask(bus.in_a, bus.in_b, SKIP_ZERO != 0), 3'd0);
        adv_nxt   = first_req(req_mask(a_q, b_q, SKIP_ZERO != 0), {1'b0, step_q} + 3'd1);

        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    acc_d = '0;
                    if (first_nxt[2]) begin
                        state_d = ST_DONE;
                        out_p_d = '0;
                    end else begin
                        state_d = ST_STEP;
                        step_d  = first_nxt[1:0];
                    end
                end
            end
            ST_STEP, ST_WAIT: begin
                if ((state_q == ST_STEP) && (MUL_LAT != 0)) begin
                    state_d = ST_WAIT;
                end else begin
                    acc_d = acc_upd;
                    if (adv_nxt[2]) begin
                        state_d = ST_DONE;
                        out_p_d = acc_upd;
                    end else begin
                        state_d = ST_STEP;
                        step_d  = adv_nxt[1:0];
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
        end
    end

    // Core operands are forced to zero when idle so the core does not toggle.
    assign bus.mul_en    = live;
    assign bus.mul_a     = live ? nib_a : 4'd0;
    assign bus.mul_b     = live ? nib_b : 4'd0;
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_p     = out_p_q;

endmodule

// File: doc/mul8u_seq_ctrl.md
Name: mul8u_seq_ctrl

Overview:
Sequential 8x8 unsigned multiplier controller that time-shares one external 4x4 unsigned multiplier core. The core is any exact or AFA-based 4x4 variant, instantiated beside this block so variants swap without touching the controller. It splits each 8-bit operand into nibbles and issues the four nibble sub-products to the core, one per step. It shifts and accumulates each result into a 16-bit product and returns it over a valid/ready handshake.

Parameters:
SKIP_ZERO, 0, 1 = skip any step whose selected a-nibble or b-nibble is zero; 0 = always run all four steps.
MUL_LAT, 0, core latency in cycles (0 = combinational core, 1 = registered core); legal values 0..1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  controller can accept operands
in_a  input  8  multiplicand
in_b  input  8  multiplier
out_valid  output  1  product available
out_ready  input  1  consumer accepts product
out_p  output  16  product
mul_en  output  1  high while mul_a/mul_b carry a live step
mul_a  output  4  nibble to core operand a
mul_b  output  4  nibble to core operand b
mul_p  input  8  core product
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- States:
  - IDLE: in_ready=1.
  - STEP: drives core operands.
  - WAIT: present only if MUL_LAT=1.
  - DONE: out_valid=1.
- Reset values: state IDLE, out_valid 0, out_p 0, accumulator 0, mul_en 0, mul_a/mul_b 0, busy 0, in_ready 1.
- Accept: at a clk edge in IDLE with in_valid=1:
  - latch in_a and in_b;
  - clear the accumulator;
  - select the first required step and go to STEP;
  - if no step is required, go to DONE (SKIP_ZERO=1 with a zero operand nibble set).
- Step order, fixed (result, operands, left shift):
  - k0: al*bl, shift 0
  - k1: ah*bl, shift 4
  - k2: al*bh, shift 4
  - k3: ah*bh, shift 8
- In STEP: mul_en=1 and mul_a/mul_b drive the step's nibbles.
  - MUL_LAT=0: on the edge, acc += mul_p << shift, then advance.
  - MUL_LAT=1: go to WAIT with operands held stable and mul_en=1; accumulate mul_p on the WAIT edge, then advance.
- Advance: go to the next required step, or to DONE after the last.
- Skipped steps consume zero cycles.
- Outside STEP/WAIT: mul_en=0 and mul_a=mul_b=0 (no core toggling).
- Accumulation is modulo 2^16. Overflow from an inexact core wraps silently; no flag.
- Timing, acceptance edge at cycle T, SKIP_ZERO=0:
  - MUL_LAT=0: steps occupy cycles T+1..T+4; out_valid=1 from T+5.
  - MUL_LAT=1: steps occupy T+1..T+8; out_valid=1 from T+9.
- DONE:
  - out_p = accumulator, stable while out_valid=1 and out_ready=0;
  - in_valid is ignored;
  - on the out_ready=1 edge go to IDLE; in_ready returns the next cycle.
- out_p holds its last value after the handshake, until the next DONE.
- No overlap: in_ready=1 only in IDLE. Throughput is one product per 6 cycles (MUL_LAT=0, SKIP_ZERO=0, out_ready tied high).
- Reset mid-operation: all outputs and state take their reset values immediately. The partial accumulation is discarded and no out_valid is produced for that request.
- out_ready held high outside DONE has no effect.

Decomposition:
- Package mul8u_seq_pkg holds:
  - state enum (IDLE, STEP, WAIT, DONE);
  - 2-bit step index type;
  - per-step nibble-select and shift constants.
- One sub-module, mul8u_step_acc: given step index, latched operands, mul_p and accumulate strobe, it produces the nibble selects and the 16-bit shifted accumulate.
- The FSM, handshake and skip logic stay in mul8u_seq_ctrl.

Test Plan:
- 0xFF*0xFF, defaults, exact core model -> mul_a/mul_b = F/F in four consecutive cycles, mul_en high for those four cycles only, out_valid at T+5, out_p=0xFE01.
- 0x12*0x34, defaults -> step operands in order (2,4), (1,4), (2,3), (1,3); out_p=0x03A8.
- Backpressure: after 0x12*0x34 completes, hold out_ready=0 for 3 cycles and pulse in_valid with new operands -> out_p stays 0x03A8, in_ready=0, new request ignored; the product is released on out_ready=1 and in_ready=1 the next cycle.
- SKIP_ZERO=1: 0x50*0x03 -> exactly one step (5,3), out_valid at T+2, out_p=0x00F0. 0x00*0xAB -> no step, mul_en never high, out_valid at T+1, out_p=0x0000.
- MUL_LAT=1 with registered core model: 0x12*0x34 -> each operand pair held 2 cycles, out_valid at T+9, out_p=0x03A8.
- Reset: assert rst during the third step of 0xFF*0xFF -> outputs at reset values the same cycle, no out_valid; then 0x0A*0x0B -> out_p=0x006E.
